// File: rtl/atpg_entry_ctrl_pkg.sv
// Shared types and constants for the ATPG/IDDQ test-mode entry controller.
// State encoding is visible on state_o, so the values are pinned.
package atpg_pkg;

  localparam int KEY_W = 16;

  localparam logic [KEY_W-1:0] KEY_ATPG_DEF = 16'hA55A;
  localparam logic [KEY_W-1:0] KEY_IDDQ_DEF = 16'h5AA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEB    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_LOCK   = 3'd4
  } state_e;

  // Key bits arrive MSB-first, so each new bit enters at the LSB end.
  function automatic logic [KEY_W-1:0] shift_in(input logic [KEY_W-1:0] key,
                                                input logic            bit_in);
    return {key[KEY_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/atpg_entry_ctrl_if.sv
// Pad-side signals of the test-mode entry controller bundled as one port.
// master = tester/pad side, slave = controller side.
interface atpg_entry_ctrl_if;

  logic       tst_i;
  logic       key_clk_i;
  logic       key_dat_i;
  logic       atpg_mode_o;
  logic       iddq_mode_o;
  logic       entry_err_o;
  logic [2:0] state_o;

  modport master (
    output tst_i, key_clk_i, key_dat_i,
    input  atpg_mode_o, iddq_mode_o, entry_err_o, state_o
  );

  modport slave (
    input  tst_i, key_clk_i, key_dat_i,
    output atpg_mode_o, iddq_mode_o, entry_err_o, state_o
  );

endinterface

// File: rtl/atpg_entry_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad. With RISE_EN set, q is a
// one-cycle rising-edge pulse (third flop); otherwise q is the synced level.
module sync_edge #(
  parameter bit RISE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  generate
    if (RISE_EN) begin : g_rise
      logic prev_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_reg <= 1'b0;
        end else begin
          prev_reg <= sync_reg;
        end
      end

      assign q = sync_reg & ~prev_reg;
    end else begin : g_level
      assign q = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/atpg_entry_ctrl.sv
// Test-mode entry controller: debounced TST qualifies entry, a 16-bit serial
// key then selects ATPG or IDDQ mode, or locks entry on a wrong key/timeout.
module atpg_entry_ctrl
  import atpg_pkg::*;
#(
  parameter int unsigned      DEB_CYC  = 8,
  parameter int unsigned      TMO_CYC  = 255,
  parameter logic [KEY_W-1:0] KEY_ATPG = KEY_ATPG_DEF,
  parameter logic [KEY_W-1:0] KEY_IDDQ = KEY_IDDQ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  atpg_entry_ctrl_if.slave   bus
);

  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  localparam logic [15:0] TMO_SAT  = 16'(TMO_CYC);

  logic [2:0] pad_raw;
  logic [2:0] pad_sync;
  logic       tst_s;
  logic       key_rise;
  logic       dat_s;

  assign pad_raw = {bus.key_dat_i, bus.key_clk_i, bus.tst_i};

  // Lane 1 (key clock) is the only one that needs an edge strobe.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge #(
        .RISE_EN (gi == 1)
      ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_raw[gi]),
        .q   (pad_sync[gi])
      );
    end
  endgenerate

  assign tst_s    = pad_sync[0];
  assign key_rise = pad_sync[1];
  assign dat_s    = pad_sync[2];

  state_e           state_reg;
  logic [7:0]       deb_cnt_reg;
  logic [15:0]      tmo_cnt_reg;
  logic [4:0]       bit_cnt_reg;
  logic [KEY_W-1:0] key_reg;
  logic             atpg_reg;
  logic             iddq_reg;
  logic             err_reg;
  logic [KEY_W-1:0] key_shift;

  assign key_shift = shift_in(key_reg, dat_s);

  // deb_cnt_reg counts qualifying TST-high cycles in DEB and TST-low cycles in ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      deb_cnt_reg <= '0;
      tmo_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      key_reg     <= '0;
      atpg_reg    <= 1'b0;
      iddq_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (tst_s) begin
            state_reg   <= ST_DEB;
            deb_cnt_reg <= '0;
          end
        end

        ST_DEB: begin
          if (!tst_s) begin
            state_reg <= ST_IDLE;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg   <= ST_SHIFT;
            key_reg     <= '0;
            bit_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 8'd1;
          end
        end

        ST_SHIFT: begin
          if (!tst_s) begin
            state_reg <= ST_IDLE;
          end else if (key_rise) begin
            key_reg     <= key_shift;
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
            tmo_cnt_reg <= '0;
            if (bit_cnt_reg == 5'd15) begin
              deb_cnt_reg <= '0;
              if (key_shift == KEY_ATPG) begin
                state_reg <= ST_ACTIVE;
                atpg_reg  <= 1'b1;
              end else if (key_shift == KEY_IDDQ) begin
                state_reg <= ST_ACTIVE;
                iddq_reg  <= 1'b1;
              end else begin
                state_reg <= ST_LOCK;
                err_reg   <= 1'b1;
              end
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            tmo_cnt_reg <= TMO_SAT;
            state_reg   <= ST_LOCK;
            err_reg     <= 1'b1;
          end else if (tmo_cnt_reg != TMO_SAT) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
        end

        ST_ACTIVE: begin
          if (tst_s) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg   <= ST_IDLE;
            atpg_reg    <= 1'b0;
            iddq_reg    <= 1'b0;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 8'd1;
          end
        end

        ST_LOCK: begin
          atpg_reg <= 1'b0;
          iddq_reg <= 1'b0;
          if (!tst_s) begin
            state_reg <= ST_IDLE;
            err_reg   <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          atpg_reg  <= 1'b0;
          iddq_reg  <= 1'b0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.atpg_mode_o = atpg_reg;
  assign bus.iddq_mode_o = iddq_reg;
  assign bus.entry_err_o = err_reg;
  assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_atpg_entry_ctrl.sv
// Directed bench for atpg_entry_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_atpg_entry_ctrl;
  import atpg_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  atpg_entry_ctrl_if bus ();

  atpg_entry_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic       a;
    logic       i;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t x;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      x = exp_q.pop_front();
      n_checks++;
      if ({bus.state_o, bus.atpg_mode_o, bus.iddq_mode_o, bus.entry_err_o} ===
          {x.st, x.a, x.i, x.e}) begin
        n_pass++;
        $display("check %s ok: state=%0d atpg=%b iddq=%b err=%b",
                 x.name, bus.state_o, bus.atpg_mode_o, bus.iddq_mode_o, bus.entry_err_o);
      end else begin
        $display("FAIL %s: got state=%0d atpg=%b iddq=%b err=%b, want state=%0d atpg=%b iddq=%b err=%b",
                 x.name, bus.state_o, bus.atpg_mode_o, bus.iddq_mode_o, bus.entry_err_o,
                 x.st, x.a, x.i, x.e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [2:0] st,
                            input logic a, input logic i, input logic e);
    exp_t x;
    x.cyc  = cyc;
    x.name = name;
    x.st   = st;
    x.a    = a;
    x.i    = i;
    x.e    = e;
    exp_q.push_back(x);
  endtask

  // TST seen by FSM 2 edges after the pad; IDLE->DEB on the 3rd edge,
  // then DEB_CYC (8) cycles in DEB before SHIFT.
  task automatic enter_shift(input string tag);
    bus.tst_i = 1'b1;
    tick(3);
    expect_now({tag, "_deb"}, 3'd1, 1'b0, 1'b0, 1'b0);
    tick(7);
    expect_now({tag, "_deb_hold"}, 3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    expect_now({tag, "_shift"}, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(9);
  endtask

  // Sends bits 15 down to 16-n, MSB first, 10 clk per bit.
  task automatic send_bits(input logic [15:0] k, input int n);
    for (int b = 15; b > 15 - n; b--) begin
      bus.key_dat_i = k[b];
      bus.key_clk_i = 1'b1;
      tick(5);
      bus.key_clk_i = 1'b0;
      tick(5);
    end
  endtask

  // 16th bit: the FSM acts on the 3rd edge after the pad rises.
  task automatic finish_key(input logic [15:0] k, input string tag,
                            input logic [2:0] st, input logic a,
                            input logic i, input logic e);
    bus.key_dat_i = k[0];
    bus.key_clk_i = 1'b1;
    tick(2);
    expect_now({tag, "_pre"}, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1);
    expect_now(tag, st, a, i, e);
    tick(2);
    bus.key_clk_i = 1'b0;
    tick(5);
  endtask

  // Exit needs 8 synced-low cycles: FSM sees low on edges 3..10.
  task automatic exit_active(input string tag, input logic a, input logic i);
    bus.tst_i = 1'b0;
    tick(9);
    expect_now({tag, "_exit_hold"}, 3'd3, a, i, 1'b0);
    tick(1);
    expect_now({tag, "_exit"}, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int leftover;
    rst           = 1'b1;
    bus.tst_i     = 1'b0;
    bus.key_clk_i = 1'b0;
    bus.key_dat_i = 1'b0;
    tick(3);
    expect_now("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(2);
    expect_now("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0);

    enter_shift("atpg");
    send_bits(16'hA55A, 15);
    finish_key(16'hA55A, "atpg_on", 3'd3, 1'b1, 1'b0, 1'b0);
    exit_active("atpg", 1'b1, 1'b0);

    enter_shift("iddq");
    send_bits(16'h5AA5, 15);
    finish_key(16'h5AA5, "iddq_on", 3'd3, 1'b0, 1'b1, 1'b0);
    exit_active("iddq", 1'b0, 1'b1);

    enter_shift("bad");
    send_bits(16'h1234, 15);
    finish_key(16'h1234, "bad_lock", 3'd4, 1'b0, 1'b0, 1'b1);
    tick(20);
    expect_now("lock_hold", 3'd4, 1'b0, 1'b0, 1'b1);
    bus.tst_i = 1'b0;
    tick(2);
    expect_now("lock_before_drop", 3'd4, 1'b0, 1'b0, 1'b1);
    tick(1);
    expect_now("lock_exit", 3'd0, 1'b0, 1'b0, 1'b0);
    tick(5);

    enter_shift("reentry");
    send_bits(16'hA55A, 15);
    finish_key(16'hA55A, "reentry_on", 3'd3, 1'b1, 1'b0, 1'b0);

    // 5 synced-low cycles in ACTIVE, then TST back high: exit count restarts.
    bus.tst_i = 1'b0;
    tick(5);
    bus.tst_i = 1'b1;
    tick(20);
    expect_now("glitch_keeps_mode", 3'd3, 1'b1, 1'b0, 1'b0);
    exit_active("after_glitch", 1'b1, 1'b0);

    // Short TST pulse: DEB reached, drop seen on the 8th edge.
    bus.tst_i = 1'b1;
    tick(3);
    expect_now("pulse_deb", 3'd1, 1'b0, 1'b0, 1'b0);
    tick(2);
    bus.tst_i = 1'b0;
    tick(3);
    expect_now("pulse_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    tick(10);
    expect_now("pulse_stays_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Last key edge acted on 3 edges into its 10-cycle slot (counter 0);
    // send_bits returns 7 edges later; the 255th idle edge locks.
    enter_shift("tmo");
    send_bits(16'hA55A, 8);
    tick(247);
    expect_now("tmo_not_yet", 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1);
    expect_now("tmo_lock", 3'd4, 1'b0, 1'b0, 1'b1);
    bus.tst_i = 1'b0;
    tick(3);
    expect_now("tmo_unlock", 3'd0, 1'b0, 1'b0, 1'b0);
    tick(5);

    enter_shift("rst_mid");
    send_bits(16'hA55A, 8);
    rst       = 1'b1;
    bus.tst_i = 1'b0;
    tick(1);
    expect_now("rst_midshift", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(3);
    expect_now("rst_midshift_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    enter_shift("rst_act");
    send_bits(16'h5AA5, 15);
    finish_key(16'h5AA5, "rst_act_on", 3'd3, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick(1);
    expect_now("rst_active", 3'd0, 1'b0, 1'b0, 1'b0);
    rst       = 1'b0;
    bus.tst_i = 1'b0;
    tick(3);

    leftover = exp_q.size();
    if (leftover != 0)
      $display("FAIL scoreboard_drain: got %0d pending, want 0", leftover);
    $display("%0d/%0d checks passed", n_pass, n_checks + ((leftover != 0) ? 1 : 0));
    $finish;
  end

endmodule

// File: doc/atpg_entry_ctrl.md
ATPG_ENTRY_CTRL -- requirements
Module: atpg_entry_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 8: consecutive synced TST cycles needed to qualify entry or exit (range 2..255).
REQ-002 Parameter TMO_CYC, default 255: idle clk cycles allowed between key edges before lock (range 16..65535).
REQ-003 Parameter KEY_ATPG, default 16'hA55A: key selecting scan/stuck-at ATPG mode.
REQ-004 Parameter KEY_IDDQ, default 16'h5AA5: key selecting IDDQ quiescent mode; SHALL differ from KEY_ATPG.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 tst_i  input  1  raw TST pad level, asynchronous.
REQ-008 key_clk_i  input  1  raw SCL pad level, asynchronous; key bit strobe.
REQ-009 key_dat_i  input  1  raw SDA pad level, asynchronous; key bit data.
REQ-010 atpg_mode_o  output  1  registered; ATPG test mode active.
REQ-011 iddq_mode_o  output  1  registered; IDDQ test mode active.
REQ-012 entry_err_o  output  1  registered; wrong key or timeout, entry locked.
REQ-013 state_o  output  3  registered FSM state encoding, for debug/observe.

Function
REQ-014 tst_i, key_clk_i, key_dat_i SHALL each pass a 2-flop synchronizer; key_clk SHALL have a third flop for rising-edge detect.
REQ-015 FSM states, encoding: IDLE=0, DEB=1, SHIFT=2, ACTIVE=3, LOCK=4; values 5..7 SHALL return to IDLE next cycle.
REQ-016 IDLE: synced tst=1 -> DEB with debounce counter cleared; else stay.
REQ-017 DEB: synced tst=0 -> IDLE; counter reaches DEB_CYC-1 with tst=1 -> SHIFT, key register and bit counter cleared.
REQ-018 SHIFT: each key_clk rising edge shifts synced key_dat into 16-bit register MSB-first, increments 5-bit bit counter, clears timeout counter.
REQ-019 SHIFT: on the edge completing bit 16, compare full key: KEY_ATPG -> ACTIVE with atpg_mode_o=1; KEY_IDDQ -> ACTIVE with iddq_mode_o=1; other -> LOCK.
REQ-020 Mode/error outputs SHALL assert on the clk edge the FSM enters ACTIVE/LOCK, one cycle after the 16th detected edge.
REQ-021 SHIFT: timeout counter reaching TMO_CYC without key edge -> LOCK; counter SHALL saturate, not wrap.
REQ-022 SHIFT: synced tst=0 -> IDLE, aborting the key; tst drop takes priority over simultaneous key edge or timeout.
REQ-023 ACTIVE: at most one of atpg_mode_o/iddq_mode_o SHALL be 1; key_clk/key_dat ignored.
REQ-024 ACTIVE: synced tst=0 for DEB_CYC consecutive cycles -> IDLE, both mode outputs cleared on that transition; a tst=1 glitch restarts the exit count.
REQ-025 LOCK: entry_err_o=1, mode outputs 0; synced tst=0 -> IDLE clearing entry_err_o; no key accepted until re-entry via DEB.
REQ-026 Key bits beyond 16 are impossible: FSM leaves SHIFT on bit 16.

Reset
REQ-027 rst=1 SHALL force state IDLE, all counters, key register and synchronizer flops 0, all outputs 0, on the next clk edge, from any state including mid-shift and ACTIVE.
REQ-028 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-029 State encoding, KEY width (16) and default key constants SHALL live in shared package atpg_pkg.
REQ-030 The synchronizer+edge detector SHALL be one reusable sub-module sync_edge (2-flop sync, optional rise pulse), instantiated three times.
REQ-031 No other sub-modules; single FSM process plus registered output logic.

Verification
REQ-032 tst=1 held 20 cycles, then 16 key edges (spacing 10 clk) shifting 16'hA55A -> state 1 then 2; atpg_mode_o=1 one cycle after 16th synced edge, iddq_mode_o=0.
REQ-033 Same with 16'h5AA5 -> iddq_mode_o=1, atpg_mode_o=0; then tst=0 for 8 cycles -> both 0, state_o=0.
REQ-034 Key 16'h1234 -> entry_err_o=1, state_o=4; tst=0 -> entry_err_o=0, state_o=0; re-entry with A55A succeeds.
REQ-035 tst=1 pulse of 5 cycles (< DEB_CYC) -> returns to IDLE, never reaches SHIFT; in ACTIVE, tst=0 for 5 cycles then 1 -> mode stays 1.
REQ-036 Enter SHIFT, 8 key edges then none for 256 cycles -> LOCK at TMO_CYC; separately rst=1 mid-shift after 8 bits -> all outputs 0, state_o=0 next cycle.
